// File: rtl/tl_initiator.sv
// rtl/tl_initiator.sv - TileLink-UL single-outstanding initiator with response timeout

package TL;
    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [2:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_ready;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [2:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
    } tilelink_d;
endpackage

module tl_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  logic [31:0]  cmd_addr,
    input  logic [31:0]  cmd_wdata,
    input  logic [3:0]   cmd_mask,
    output TL::tilelink_a bus_tla,
    input  TL::tilelink_d bus_tld,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    output logic         rsp_error,
    output logic         rsp_timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_e;

    // A channel idles low with a_ready tied high, even straight out of reset
    localparam TL::tilelink_a TLA_RESET = '{a_ready: 1'b1, default: '0};

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    TL::tilelink_a tla_q, tla_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_error_q, rsp_error_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    logic          d_hit;
    logic          expire;
    logic          op_bad;

    // Fields of the D beat this initiator has no use for
    logic unused_tld;
    assign unused_tld = ^{bus_tld.d_param, bus_tld.d_size, bus_tld.d_source, bus_tld.d_sink};

    assign d_hit  = (state_q == ST_WAIT) && bus_tld.d_valid;
    // A response in the last allowed cycle takes priority over the timeout
    assign expire = (state_q == ST_WAIT) && !bus_tld.d_valid && (cnt_q == 8'(TIMEOUT - 1));
    assign op_bad = write_q ? !(bus_tld.d_opcode == TL::AccessAck || bus_tld.d_opcode == TL::AccessAckData)
                            : (bus_tld.d_opcode != TL::AccessAckData);

    assign bus_tla     = tla_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

    // State, counter, latched command, A-channel and response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            write_q       <= 1'b0;
            tla_q         <= TLA_RESET;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            tla_q         <= tla_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next state and WAIT-cycle counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT;
                cnt_d   = 8'd0;
            end
            ST_WAIT: begin
                if (d_hit || expire) state_d = ST_IDLE;
                else                 cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: command handshake, A beat build-up and response capture
    always_comb begin
        cmd_ready     = (state_q == ST_IDLE) && !reset;
        write_d       = write_q;
        tla_d         = tla_q;
        tla_d.a_valid = 1'b0;
        tla_d.a_ready = 1'b1;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        // The A beat is loaded at the accept edge so it is on the bus during SEND only
        if (state_q == ST_IDLE && cmd_valid) begin
            write_d          = cmd_write;
            tla_d.a_valid    = 1'b1;
            tla_d.a_param    = 3'd0;
            tla_d.a_size     = 3'd2;
            tla_d.a_source   = 8'd0;
            tla_d.a_address  = cmd_addr;
            if (cmd_write) begin
                tla_d.a_opcode = (cmd_mask == 4'hF) ? TL::PutFullData : TL::PutPartialData;
                tla_d.a_mask   = cmd_mask;
                tla_d.a_data   = cmd_wdata;
            end else begin
                tla_d.a_opcode = TL::Get;
                tla_d.a_mask   = 4'hF;
                tla_d.a_data   = 32'd0;
            end
        end

        if (d_hit) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = write_q ? 32'd0 : bus_tld.d_data;
            rsp_error_d   = bus_tld.d_error | op_bad;
        end else if (expire) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = 32'd0;
            rsp_error_d   = 1'b1;
        end
    end

endmodule

// File: tb/tb_tl_initiator.sv
// tb/tb_tl_initiator.sv - directed bench for tl_initiator with a one-word register responder

module tb_tl_initiator;

    localparam logic [31:0] MAPPED = 32'hF000_0000;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_mask;
    TL::tilelink_a bus_tla;
    TL::tilelink_d tld;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_word;

    int          o_beats;
    int          o_lat;
    logic [2:0]  o_op;
    logic [3:0]  o_mask;
    logic [31:0] o_data;
    logic [31:0] o_addr;
    logic [2:0]  o_size;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_to;
    logic        o_rdy;

    tl_initiator #(.TIMEOUT(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_mask    (cmd_mask),
        .bus_tla     (bus_tla),
        .bus_tld     (tld),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, act as the slave, and record what was seen on the bus.
    // dly = WAIT-cycle index in which d_valid is driven (0 = next-cycle), -1 = never.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input int dly, input logic derr, input logic bad_op);
        logic [31:0] beat_addr;
        logic        beat_get;
        bit          done;
        done = 0; beat_addr = 32'd0; beat_get = 1'b0;
        o_beats = 0; o_lat = -1; o_op = 3'h7; o_mask = 4'h0; o_data = 32'h0;
        o_addr = 32'h0; o_size = 3'h0; o_rdata = 32'hX; o_err = 1'bX; o_to = 1'bX; o_rdy = 1'bX;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
        @(posedge clock); #1;
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 32'h5555_5550; cmd_wdata = 32'hA5A5_A5A5; cmd_mask = 4'h0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            if (bus_tla.a_valid) begin
                o_beats++;
                o_op = bus_tla.a_opcode; o_mask = bus_tla.a_mask; o_data = bus_tla.a_data;
                o_addr = bus_tla.a_address; o_size = bus_tla.a_size;
                beat_addr = bus_tla.a_address;
                beat_get  = (bus_tla.a_opcode == TL::Get);
                if (!beat_get && beat_addr == MAPPED)
                    for (int b = 0; b < 4; b++)
                        if (bus_tla.a_mask[b]) mem_word[8*b +: 8] = bus_tla.a_data[8*b +: 8];
            end
            if (rsp_valid) begin
                o_lat = cyc; o_rdata = rsp_rdata; o_err = rsp_error; o_to = rsp_timeout; o_rdy = cmd_ready;
                done = 1;
            end else begin
                if (dly >= 0 && cyc - 2 == dly) begin
                    tld.d_valid  = 1'b1;
                    tld.d_error  = derr;
                    tld.d_opcode = beat_get ? (bad_op ? TL::AccessAck : TL::AccessAckData) : TL::AccessAck;
                    tld.d_size   = 3'd2;
                    tld.d_data   = (beat_get && beat_addr == MAPPED) ? mem_word : 32'd0;
                end
                @(posedge clock); #1;
                tld = '0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_wdata = 32'd0; cmd_mask = 4'd0; tld = '0; mem_word = 32'd0;
        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_a_valid", bus_tla.a_valid, 0);
        chk("rst_a_ready", bus_tla.a_ready, 1);
        chk("rst_a_address", bus_tla.a_address, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);

        // Full write
        txn(1'b1, MAPPED, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b0);
        chk("fw_beats", o_beats, 1);
        chk("fw_opcode", o_op, 0);
        chk("fw_addr", o_addr, 32'hF000_0000);
        chk("fw_data", o_data, 32'hDEAD_BEEF);
        chk("fw_mask", o_mask, 4'hF);
        chk("fw_size", o_size, 2);
        chk("fw_latency", o_lat, 3);
        chk("fw_error", o_err, 0);
        chk("fw_rdata", o_rdata, 0);
        chk("fw_timeout", o_to, 0);
        chk("fw_ready_at_rsp", o_rdy, 1);
        @(posedge clock); #1;
        chk("fw_rsp_pulse", rsp_valid, 0);
        chk("fw_a_idle", bus_tla.a_valid, 0);
        chk("fw_a_addr_held", bus_tla.a_address, 32'hF000_0000);

        // Read-back, ignored mask forced to F
        txn(1'b0, MAPPED, 32'h1234_5678, 4'h0, 0, 1'b0, 1'b0);
        chk("rd_opcode", o_op, 4);
        chk("rd_mask", o_mask, 4'hF);
        chk("rd_data", o_data, 0);
        chk("rd_rdata", o_rdata, 32'hDEAD_BEEF);
        chk("rd_error", o_err, 0);
        chk("rd_latency", o_lat, 3);

        // Partial write issued in the response cycle of the read
        txn(1'b1, MAPPED, 32'h0000_1234, 4'h3, 0, 1'b0, 1'b0);
        chk("pw_beats", o_beats, 1);
        chk("pw_opcode", o_op, 1);
        chk("pw_mask", o_mask, 4'h3);
        chk("pw_data", o_data, 32'h0000_1234);
        chk("pw_error", o_err, 0);
        txn(1'b0, MAPPED, 32'h0, 4'hF, 0, 1'b0, 1'b0);
        chk("pw_readback", o_rdata, 32'hDEAD_1234);

        // Stray d_valid while idle
        tld.d_valid = 1'b1; tld.d_opcode = TL::AccessAckData; tld.d_data = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        tld = '0;
        chk("stray_rsp_valid", rsp_valid, 0);
        chk("stray_cmd_ready", cmd_ready, 1);
        chk("stray_rdata_held", rsp_rdata, 32'hDEAD_1234);
        @(posedge clock); #1;
        chk("stray_rsp_valid2", rsp_valid, 0);

        // Timeout on unmapped address
        txn(1'b0, 32'h1000_0000, 32'h0, 4'h0, -1, 1'b0, 1'b0);
        chk("to_latency", o_lat, 18);
        chk("to_timeout", o_to, 1);
        chk("to_error", o_err, 1);
        chk("to_rdata", o_rdata, 0);
        chk("to_ready", o_rdy, 1);

        // Response in the 16th WAIT cycle wins
        txn(1'b0, MAPPED, 32'h0, 4'h0, 15, 1'b0, 1'b0);
        chk("late_latency", o_lat, 18);
        chk("late_timeout", o_to, 0);
        chk("late_error", o_err, 0);
        chk("late_rdata", o_rdata, 32'hDEAD_1234);

        // Slave error on a Get
        txn(1'b0, MAPPED, 32'h0, 4'h0, 0, 1'b1, 1'b0);
        chk("derr_error", o_err, 1);
        chk("derr_timeout", o_to, 0);
        chk("derr_rdata", o_rdata, 32'hDEAD_1234);

        // AccessAck returned for a Get
        txn(1'b0, MAPPED, 32'h0, 4'h0, 0, 1'b0, 1'b1);
        chk("badop_error", o_err, 1);
        chk("badop_timeout", o_to, 0);

        // Reset during WAIT, then a late d_valid
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = MAPPED; cmd_mask = 4'hF;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(posedge clock); #1;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_a_valid", bus_tla.a_valid, 0);
        chk("mid_rst_a_addr", bus_tla.a_address, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        tld.d_valid = 1'b1; tld.d_opcode = TL::AccessAckData; tld.d_data = 32'h7777_7777;
        @(posedge clock); #1;
        tld = '0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_rsp", rsp_valid, 0);
            @(posedge clock); #1;
        end
        chk("post_rst_rdata", rsp_rdata, 0);
        chk("post_rst_ready", cmd_ready, 1);

        // Clean write/read after reset
        txn(1'b1, MAPPED, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 1'b0);
        chk("clean_w_opcode", o_op, 0);
        chk("clean_w_latency", o_lat, 3);
        chk("clean_w_error", o_err, 0);
        txn(1'b0, MAPPED, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        chk("clean_r_rdata", o_rdata, 32'hCAFE_F00D);
        chk("clean_r_error", o_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
